// File: rtl/vote_poller_pkg.sv
// vote_pkg: shared FSM state type and count-width helper for the vote poller.
package vote_pkg;
    typedef enum logic [1:0] {IDLE, POLL, GAP, DONE} poll_state_t;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/vote_timer.sv
// vote_timer: per-voter wait counter; expired flags the last allowed request cycle.
module vote_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] count;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + 1'b1;
    assign expired = count == TW'(TIMEOUT - 1);
endmodule

// File: rtl/vote_poller.sv
// vote_poller: serial req/ack ballot initiator with registered majority decision.
// Optional VOTE_POLLER_EARLY_DECIDE_EN stops polling once the outcome is settled.
module vote_poller
    import vote_pkg::*;
#(
    parameter int N_VOTERS  = 4,
    parameter int THRESHOLD = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [N_VOTERS-1:0]           ballot_req,
    input  logic                          ballot_ack,
    input  logic                          ballot_vote,
    output logic                          busy,
    output logic                          result_valid,
    output logic                          result,
    output logic [cnt_w(N_VOTERS)-1:0]    yes_count,
    output logic [cnt_w(N_VOTERS)-1:0]    abstain_count
);
    localparam int CW = cnt_w(N_VOTERS);
    localparam int IW = $clog2(N_VOTERS);
    poll_state_t   state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [CW-1:0] yes_n, abs_n;
    logic          clr, en, expired, last, stop;

    vote_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .expired(expired)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        yes_n   = yes_count;
        abs_n   = abstain_count;
        clr     = 1'b0;
        en      = 1'b0;
        stop    = 1'b0;
        last    = idx == IW'(N_VOTERS - 1);
        case (state)
            IDLE: if (start) begin
                state_n = POLL;
                idx_n   = '0;
                yes_n   = '0;
                abs_n   = '0;
                clr     = 1'b1;
            end
            POLL: begin
                en = 1'b1;
                // an ack on the timeout cycle still counts as a vote
                if (ballot_ack || expired) begin
                    clr   = 1'b1;
                    yes_n = yes_count + CW'(ballot_ack && ballot_vote);
                    abs_n = abstain_count + CW'(!ballot_ack);
`ifdef VOTE_POLLER_EARLY_DECIDE_EN
                    stop  = last || int'(yes_n) >= THRESHOLD ||
                            int'(yes_n) + N_VOTERS - 1 - int'(idx) < THRESHOLD;
`else
                    stop  = last;
`endif
                    state_n = stop ? DONE : GAP;
                end
            end
            GAP: begin
                idx_n   = idx + 1'b1;
                state_n = POLL;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            yes_count     <= '0;
            abstain_count <= '0;
            ballot_req    <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result        <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            yes_count     <= yes_n;
            abstain_count <= abs_n;
            ballot_req    <= state_n == POLL ? N_VOTERS'(1) << idx_n : '0;
            // busy stays up through the result_valid cycle
            busy          <= state_n != IDLE || state == DONE;
            result_valid  <= state == DONE;
            result        <= state == DONE ? yes_count >= CW'(THRESHOLD) : result;
        end
endmodule

// File: tb/tb_vote_poller.sv
// tb_vote_poller: table-driven rounds with a scoreboard of expected decisions plus reset/stray-start sequences.
module tb_vote_poller;
    localparam int N  = 4;
    localparam int TO = 15;
`ifdef VOTE_POLLER_EARLY_DECIDE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [3:0]      v;
        logic [7:0]      yes_d, abs_d, yes_e, abs_e, np_e;
        logic            res;
    } vec_t;
    typedef struct {
        int yes, ab, res, lat;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ack = 1'b0, vote = 1'b0;
    logic [3:0] ballot_req;
    logic       busy, result_valid, result;
    logic [2:0] yes_count, abstain_count;
    int         n_checks = 0, n_fail = 0;
    vec_t       tbl[8];
    exp_t       sbq[$];

    vote_poller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ballot_req(ballot_req),
        .ballot_ack(ack), .ballot_vote(vote), .busy(busy),
        .result_valid(result_valid), .result(result),
        .yes_count(yes_count), .abstain_count(abstain_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d0, d1, d2, d3, input logic [3:0] v,
                                input int yd, ad, ye, ae, npe, input logic res);
        vec_t r;
        r.d[0] = 8'(d0); r.d[1] = 8'(d1); r.d[2] = 8'(d2); r.d[3] = 8'(d3);
        r.v = v; r.yes_d = 8'(yd); r.abs_d = 8'(ad); r.yes_e = 8'(ye);
        r.abs_e = 8'(ae); r.np_e = 8'(npe); r.res = res;
        return r;
    endfunction

    task automatic run_round(input vec_t t, input int id);
        logic [3:0] tl[$];
        int   np, lat, c, v, h;
        int   held[4];
        bit   done;
        exp_t e;
        np = EARLY ? int'(t.np_e) : N;
        for (int i = 0; i < np; i++) begin
            h = int'(t.d[i]) < TO ? int'(t.d[i]) + 1 : TO;
            repeat (h) tl.push_back(4'(1 << i));
            if (i < np - 1) tl.push_back(4'b0);
        end
        lat = tl.size() + 1;
        e.yes = EARLY ? int'(t.yes_e) : int'(t.yes_d);
        e.ab  = EARLY ? int'(t.abs_e) : int'(t.abs_d);
        e.res = int'(t.res);
        e.lat = lat;
        sbq.push_back(e);
        for (int i = 0; i < 4; i++) held[i] = 0;
        @(negedge clk);
        start = 1'b1;
        ack   = 1'b0;
        c     = 0;
        done  = 1'b0;
        while (!done && c < 200) begin
            @(negedge clk);
            start = (c == 3 && lat > 5);
            chk($sformatf("r%0d_req_c%0d", id, c), int'(ballot_req), c < tl.size() ? int'(tl[c]) : 0);
            chk($sformatf("r%0d_busy_c%0d", id, c), int'(busy), 1);
            if (result_valid) begin
                done = 1'b1;
                if (sbq.size() == 0) chk($sformatf("r%0d_sb_empty", id), 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk($sformatf("r%0d_latency", id), c, e.lat);
                    chk($sformatf("r%0d_yes", id), int'(yes_count), e.yes);
                    chk($sformatf("r%0d_abstain", id), int'(abstain_count), e.ab);
                    chk($sformatf("r%0d_result", id), int'(result), e.res);
                end
            end
            if (ballot_req != 0) begin
                v = 0;
                for (int i = 0; i < 4; i++) if (ballot_req[i]) v = i;
                held[v]++;
                ack  = (held[v] - 1 == int'(t.d[v]));
                vote = ack ? t.v[v] : 1'($urandom_range(0, 1));
            end else begin
                ack  = 1'($urandom_range(0, 1));
                vote = 1'($urandom_range(0, 1));
            end
            c++;
        end
        if (!done) chk($sformatf("r%0d_timeout", id), 0, 1);
        ack   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("r%0d_busy_after", id), int'(busy), 0);
        chk($sformatf("r%0d_rv_width", id), int'(result_valid), 0);
        chk($sformatf("r%0d_yes_held", id), int'(yes_count), e.yes);
        chk($sformatf("r%0d_res_held", id), int'(result), e.res);
    endtask

    initial begin
        bit hit;
        tbl[0] = mk(0, 0, 0, 0, 4'b0111, 3, 0, 3, 0, 3, 1'b1);
        tbl[1] = mk(0, 0, 0, 0, 4'b0101, 2, 0, 2, 0, 4, 1'b0);
        tbl[2] = mk(0, 0, 99, 0, 4'b1011, 3, 1, 3, 1, 4, 1'b1);
        tbl[3] = mk(0, 0, 14, 0, 4'b1110, 3, 0, 3, 0, 4, 1'b1);
        tbl[4] = mk(0, 0, 0, 0, 4'b1100, 2, 0, 0, 0, 2, 1'b0);
        tbl[5] = mk(3, 1, 2, 0, 4'b1011, 3, 0, 3, 0, 4, 1'b1);
        tbl[6] = mk(99, 99, 99, 99, 4'b0000, 0, 4, 0, 2, 2, 1'b0);
        tbl[7] = mk(0, 0, 0, 0, 4'b1111, 4, 0, 3, 0, 3, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_req", int'(ballot_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_yes", int'(yes_count), 0);
        chk("rst_abs", int'(abstain_count), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_round(tbl[i], i);

        // async reset while polling voter 2
        @(negedge clk);
        start = 1'b1;
        ack   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (ballot_req == 4'b0100) hit = 1'b1;
            else begin
                ack  = ballot_req != 0;
                vote = 1'b1;
                @(negedge clk);
            end
        end
        chk("mid_reached_idx2", int'(hit), 1);
        chk("mid_yes_before", int'(yes_count), 2);
        ack   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", int'(ballot_req), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_yes", int'(yes_count), 0);
        chk("mid_rst_abs", int'(abstain_count), 0);
        chk("mid_rst_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_round(tbl[0], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
